// File: rtl/gate_truth_checker_pkg.sv
// gate_chk_pkg: shared types and constants for the gate truth checker.
//   chk_state_e : controller states
//   TT_*        : 2-input truth tables, bit i = expected output for vector i
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } chk_state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_if.sv
// gate_truth_checker_if: bundle between a sweep requester / gate under test
// and the checker.
//   start            requester -> checker  sweep request
//   gate_out         gate      -> checker  result of the gate under test
//   gate_in          checker   -> gate     vector being applied
//   busy, done, pass, err_count, first_fail_vec, first_fail_valid
//                    checker   -> requester status and results
// Modports: master = requester/gate side, slave = checker.
interface gate_truth_checker_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;

    modport master (
        output start, gate_out,
        input  gate_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, gate_out,
        output gate_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/gate_truth_checker_settle_cnt.sv
// gate_chk_settle_cnt: loadable down-counter timing how long a vector is held.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : reload to SETTLE-1 (asserted on entry to APPLY)
//   en       : counting enabled (controller in APPLY)
//   expire   : final settle cycle; controller moves on at the next edge
module gate_chk_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int            CW       = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    // Loading SETTLE-1 makes expire fire on the SETTLE-th cycle in APPLY.
    assign expire = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input vector of an N_IN-input combinational
// gate in ascending order, holds each for SETTLE cycles, samples the gate and
// compares against TRUTH. Reports mismatch count, first failing vector, pass.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gate_truth_checker_if.slave (start/gate_out in, gate_in and
//              results out)
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b0111,
    parameter int                     SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_truth_checker_if.slave  bus
);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    chk_state_e      state;
    logic [N_IN-1:0] vec;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] ff_vec;
    logic            ff_vld;
    logic            busy_q;
    logic            done_q;

    logic            start_ok;
    logic            cnt_load;
    logic            cnt_expire;
    logic            mismatch;

    // start only counts when no sweep is in flight
    assign start_ok = bus.start && (state == IDLE || state == DONE);
    assign cnt_load = start_ok || (state == SAMPLE && vec != VEC_LAST);

    // Case inequality so an X/Z from the gate is a failure in simulation.
    assign mismatch = (bus.gate_out !== TRUTH[vec]);

    gate_chk_settle_cnt #(.SETTLE(SETTLE)) u_settle (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .en     (state == APPLY),
        .expire (cnt_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            vec     <= '0;
            err_cnt <= '0;
            ff_vec  <= '0;
            ff_vld  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= APPLY;
                        vec     <= '0;
                        err_cnt <= '0;
                        ff_vec  <= '0;
                        ff_vld  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (cnt_expire)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!ff_vld) begin
                            ff_vec <= vec;
                            ff_vld <= 1'b1;
                        end
                    end
                    // vec stays on the last vector so gate_in holds in DONE
                    if (vec == VEC_LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gate_in          = vec;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = done_q && (err_cnt == '0);
    assign bus.err_count        = err_cnt;
    assign bus.first_fail_vec   = ff_vec;
    assign bus.first_fail_valid = ff_vld;
endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three checker instances.
//   A: 2-input, TRUTH=NAND, gate model = tb-chosen table act_tt
//   B: 2-input, TRUTH=AND, real AND gate, start shared with A
//   C: 3-input, SETTLE=3, TRUTH=3-input NAND, real 3-input NAND gate
module tb_gate_truth_checker;
    import gate_chk_pkg::*;

    logic clk;
    logic rst;
    logic [3:0] act_tt;

    int n_chk  = 0;
    int n_pass = 0;

    gate_truth_checker_if #(.N_IN(2)) ifa ();
    gate_truth_checker_if #(.N_IN(2)) ifb ();
    gate_truth_checker_if #(.N_IN(3)) ifc ();

    gate_truth_checker #(.N_IN(2), .TRUTH(TT_NAND), .SETTLE(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    gate_truth_checker #(.N_IN(2), .TRUTH(TT_AND), .SETTLE(1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));
    gate_truth_checker #(.N_IN(3), .TRUTH(8'b0111_1111), .SETTLE(3)) dut_c (
        .clk (clk), .rst (rst), .bus (ifc.slave));

    // Gates under test
    assign ifb.start = ifa.start;
    always_comb ifa.gate_out = act_tt[ifa.gate_in];
    always_comb ifb.gate_out = ifb.gate_in[1] & ifb.gate_in[0];
    always_comb ifc.gate_out = !(ifc.gate_in[2] & ifc.gate_in[1] & ifc.gate_in[0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: a 2-input NAND is 0 only when both inputs are 1.
    function automatic bit nand2(input int v);
        return !((v & 1) != 0 && (v & 2) != 0);
    endfunction

    // Expected results for a gate behaving as table t, checked against NAND
    task automatic model_a(input logic [3:0] t, output int e_err, output int e_ff,
                           output int e_vld);
        e_err = 0; e_ff = 0; e_vld = 0;
        for (int v = 0; v < 4; v++) begin
            if (t[v] != nand2(v)) begin
                e_err++;
                if (e_vld == 0) begin
                    e_ff  = v;
                    e_vld = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on A/B. trace checks gate_in stepping; a start pulse is
    // injected inj cycles after the sweep begins (negative: none).
    task automatic sweep_a(input bit trace, input int inj, output int cyc);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        check("busy_at_start", ifa.busy, 1);
        check("done_at_start", ifa.done, 0);
        check("pass_at_start", ifa.pass, 0);
        check("err_at_start", ifa.err_count, 0);
        check("ffvld_at_start", ifa.first_fail_valid, 0);
        check("gate_in_at_start", ifa.gate_in, 0);
        cyc = 0;
        while (!ifa.done && cyc < 100) begin
            if (trace) check("gate_in_step", ifa.gate_in, cyc / 2);
            ifa.start = (cyc == inj);
            tick();
            cyc++;
        end
        ifa.start = 1'b0;
        check("sweep_latency", cyc, 8);
        check("busy_in_done", ifa.busy, 0);
        check("gate_in_holds_last", ifa.gate_in, 3);
    endtask

    task automatic results_a(input string tag, input logic [3:0] t);
        int e_err, e_ff, e_vld;
        model_a(t, e_err, e_ff, e_vld);
        check({tag, "_err"}, ifa.err_count, e_err);
        check({tag, "_ffvec"}, ifa.first_fail_vec, e_ff);
        check({tag, "_ffvld"}, ifa.first_fail_valid, e_vld);
        check({tag, "_pass"}, ifa.pass, (e_err == 0) ? 1 : 0);
        // B always sees a correct AND against an AND table
        check({tag, "_b_done"}, ifb.done, 1);
        check({tag, "_b_pass"}, ifb.pass, 1);
        check({tag, "_b_err"}, ifb.err_count, 0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        ifa.start = 1'b0;
        ifc.start = 1'b0;
        act_tt    = 4'b0111;
        tick();
        tick();
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_pass", ifa.pass, 0);
        check("rst_err", ifa.err_count, 0);
        check("rst_gate_in", ifa.gate_in, 0);
        check("rst_ffvld", ifa.first_fail_valid, 0);
        rst = 1'b0;
        tick();

        // Correct NAND, with gate_in stepping traced
        act_tt = 4'b0111;
        sweep_a(1'b1, -1, cyc);
        results_a("nand", act_tt);
        repeat (3) tick();
        check("results_stable", ifa.pass, 1);

        // Stuck-at-1 output
        act_tt = 4'b1111;
        sweep_a(1'b0, -1, cyc);
        results_a("stuck1", act_tt);

        // AND gate checked against NAND table; restart from DONE clears results
        act_tt = 4'b1000;
        sweep_a(1'b0, -1, cyc);
        results_a("and_vs_nand", act_tt);

        // start pulse while busy is ignored
        act_tt = 4'b0111;
        sweep_a(1'b0, 3, cyc);
        results_a("start_in_busy", act_tt);

        // Reset mid-sweep at edge k+4
        act_tt    = 4'b1111;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", ifa.busy, 0);
        check("midrst_done", ifa.done, 0);
        check("midrst_err", ifa.err_count, 0);
        check("midrst_gate_in", ifa.gate_in, 0);
        check("midrst_ffvld", ifa.first_fail_valid, 0);
        check("midrst_b_busy", ifb.busy, 0);
        repeat (2) tick();
        check("idle_after_rst", ifa.busy, 0);
        act_tt = 4'b0111;
        sweep_a(1'b0, -1, cyc);
        results_a("after_rst", act_tt);

        // Random gate behaviours against the NAND table
        for (int r = 0; r < 8; r++) begin
            act_tt = 4'($urandom_range(0, 15));
            sweep_a(1'b0, $urandom_range(0, 9) - 2, cyc);
            results_a("random", act_tt);
        end

        // 3-input NAND with SETTLE=3
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        check("c_busy_at_start", ifc.busy, 1);
        cyc = 0;
        while (!ifc.done && cyc < 200) begin
            check("c_gate_in_step", ifc.gate_in, cyc / 4);
            tick();
            cyc++;
        end
        check("c_latency", cyc, 32);
        check("c_pass", ifc.pass, 1);
        check("c_err", ifc.err_count, 0);
        check("c_ffvld", ifc.first_fail_valid, 0);
        check("c_gate_in_last", ifc.gate_in, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
